// File: rtl/line_word_burst_unit.sv
// line_word_burst_unit: buffers one cache line and hands it to the CPU data
// port as either the single addressed word or a critical-word-first burst
// that wraps around the end of the line. Both sides use valid/ready.
module line_word_burst_unit #(
  parameter int CPU_DATA_SIZE  = 16,
  parameter int WORDS_PER_LINE = 4,
  parameter int BYTE_SEL_SIZE  = 1
) (
  input  logic                                             IN_CLK,
  input  logic                                             IN_RESET_N,
  input  logic                                             IN_LINE_VALID,
  output logic                                             OUT_LINE_READY,
  input  logic [CPU_DATA_SIZE*WORDS_PER_LINE-1:0]          IN_LINE_DATA,
  input  logic [$clog2(WORDS_PER_LINE)+BYTE_SEL_SIZE-1:0]  IN_ADDR_OFFSET,
  input  logic                                             IN_MODE,
  input  logic                                             IN_FLUSH,
  output logic                                             OUT_WORD_VALID,
  input  logic                                             IN_WORD_READY,
  output logic [CPU_DATA_SIZE-1:0]                         OUT_WORD_DATA,
  output logic [$clog2(WORDS_PER_LINE)-1:0]                OUT_WORD_INDEX,
  output logic                                             OUT_WORD_LAST,
  output logic                                             OUT_BUSY
);

  localparam int WORD_SEL_SIZE = $clog2(WORDS_PER_LINE);
  localparam int LINE_SIZE     = CPU_DATA_SIZE * WORDS_PER_LINE;
  localparam int OFFSET_SIZE   = WORD_SEL_SIZE + BYTE_SEL_SIZE;

  localparam logic [WORD_SEL_SIZE-1:0] LAST_COUNT = WORD_SEL_SIZE'(WORDS_PER_LINE - 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;

  logic [0:0]                                   state;
  logic [WORDS_PER_LINE-1:0][CPU_DATA_SIZE-1:0] line_buf;
  logic [WORD_SEL_SIZE-1:0]                     start_idx;
  logic [WORD_SEL_SIZE-1:0]                     count;
  logic                                         mode;
  logic [WORD_SEL_SIZE-1:0]                     index;
  logic                                         busy;
  logic                                         last;
  logic                                         accept;
  logic                                         word_fire;

  // Byte-select bits of the offset carry no meaning for a word-granular path.
  logic unused_offset;
  assign unused_offset = ^IN_ADDR_OFFSET;

  assign busy      = (state == SEND);
  assign accept    = IN_LINE_VALID && OUT_LINE_READY;
  assign word_fire = busy && IN_WORD_READY;

  // Word index wraps naturally because the sum is kept to WORD_SEL_SIZE bits.
  always_comb begin
    index = start_idx + count;
    last  = !mode || (count == LAST_COUNT);
  end

  // Word outputs decode only registered state and are forced to zero outside SEND.
  always_comb begin
    OUT_LINE_READY = (state == IDLE) && !IN_FLUSH;
    OUT_BUSY       = busy;
    OUT_WORD_VALID = busy;
    OUT_WORD_DATA  = busy ? line_buf[index] : '0;
    OUT_WORD_INDEX = busy ? index : '0;
    OUT_WORD_LAST  = busy && last;
  end

  // Sequencer: flush beats the word handshake and line accept.
  always_ff @(posedge IN_CLK or negedge IN_RESET_N) begin
    if (!IN_RESET_N) begin
      state     <= IDLE;
      line_buf  <= '0;
      start_idx <= '0;
      count     <= '0;
      mode      <= 1'b0;
    end else if (IN_FLUSH) begin
      state <= IDLE;
    end else if (accept) begin
      line_buf  <= IN_LINE_DATA[LINE_SIZE-1:0];
      start_idx <= IN_ADDR_OFFSET[OFFSET_SIZE-1 -: WORD_SEL_SIZE];
      mode      <= IN_MODE;
      count     <= '0;
      state     <= SEND;
    end else if (word_fire) begin
      if (last) state <= IDLE;
      else      count <= count + 1'b1;
    end
  end

endmodule

// File: tb/tb_line_word_burst_unit.sv
// tb_line_word_burst_unit: directed test-plan scenarios plus random traffic,
// each cycle compared against a queue of words the bench expects to see.
module tb_line_word_burst_unit;

  localparam int W = 16;
  localparam int N = 4;
  localparam logic [63:0] TEST_LINE = 64'h4444_3333_2222_1111;

  logic        clk;
  logic        rst_n;
  logic        line_valid;
  logic        line_ready;
  logic [63:0] line_data;
  logic [2:0]  addr_offset;
  logic        mode;
  logic        flush;
  logic        word_valid;
  logic        word_ready;
  logic [15:0] word_data;
  logic [1:0]  word_index;
  logic        word_last;
  logic        busy;

  typedef struct {
    logic [15:0] data;
    logic [1:0]  idx;
    logic        last;
  } exp_word_t;

  exp_word_t pending[$];

  int n_checks = 0;
  int n_pass   = 0;

  line_word_burst_unit #(
    .CPU_DATA_SIZE (W),
    .WORDS_PER_LINE(N),
    .BYTE_SEL_SIZE (1)
  ) dut (
    .IN_CLK        (clk),
    .IN_RESET_N    (rst_n),
    .IN_LINE_VALID (line_valid),
    .OUT_LINE_READY(line_ready),
    .IN_LINE_DATA  (line_data),
    .IN_ADDR_OFFSET(addr_offset),
    .IN_MODE       (mode),
    .IN_FLUSH      (flush),
    .OUT_WORD_VALID(word_valid),
    .IN_WORD_READY (word_ready),
    .OUT_WORD_DATA (word_data),
    .OUT_WORD_INDEX(word_index),
    .OUT_WORD_LAST (word_last),
    .OUT_BUSY      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Expected word list for one accepted line: critical word first, wrapping.
  task automatic load_line(input logic [63:0] ld, input logic [2:0] off, input bit md);
    int unsigned start;
    int unsigned n_words;
    exp_word_t e;
    start   = int'(off) / 2;
    n_words = md ? N : 1;
    for (int unsigned k = 0; k < n_words; k++) begin
      e.idx  = 2'((start + k) % N);
      e.data = 16'(ld >> (W * int'(e.idx)));
      e.last = (k == n_words - 1);
      pending.push_back(e);
    end
  endtask

  task automatic check_outputs(input bit fl);
    if (pending.size() > 0) begin
      check("valid", 64'(word_valid), 64'd1);
      check("busy",  64'(busy),       64'd1);
      check("data",  64'(word_data),  64'(pending[0].data));
      check("index", 64'(word_index), 64'(pending[0].idx));
      check("last",  64'(word_last),  64'(pending[0].last));
      check("ready", 64'(line_ready), 64'd0);
    end else begin
      check("valid", 64'(word_valid), 64'd0);
      check("busy",  64'(busy),       64'd0);
      check("data",  64'(word_data),  64'd0);
      check("index", 64'(word_index), 64'd0);
      check("last",  64'(word_last),  64'd0);
      check("ready", 64'(line_ready), fl ? 64'd0 : 64'd1);
    end
  endtask

  // One cycle: drive after the falling edge, check, then advance the model.
  task automatic step(input bit lv, input logic [63:0] ld, input logic [2:0] off,
                      input bit md, input bit rdy, input bit fl);
    line_valid  = lv;
    line_data   = ld;
    addr_offset = off;
    mode        = md;
    word_ready  = rdy;
    flush       = fl;
    #1;
    check_outputs(fl);
    @(posedge clk);
    if (fl) pending.delete();
    else if (pending.size() == 0) begin
      if (lv) load_line(ld, off, md);
    end else if (rdy) void'(pending.pop_front());
    @(negedge clk);
  endtask

  task automatic idle_cycles(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(1'b0, 64'($urandom), 3'($urandom), 1'($urandom), rdy, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; line_valid = 1'b0; line_data = '0; addr_offset = '0;
    mode = 1'b0; flush = 1'b0; word_ready = 1'b0;
    #3;
    check_outputs(1'b0);
    flush = 1'b1; #1;
    check("rst_ready_flush", 64'(line_ready), 64'd0);
    flush = 1'b0;
    #8 rst_n = 1'b1;
    @(negedge clk);

    // 1: burst from word 2, ready held high
    step(1'b1, TEST_LINE, 3'b101, 1'b1, 1'b1, 1'b0);
    idle_cycles(4, 1'b1);
    idle_cycles(1, 1'b1);

    // 2: single word 3
    step(1'b1, TEST_LINE, 3'b110, 1'b0, 1'b1, 1'b0);
    idle_cycles(2, 1'b1);

    // 3: burst from word 0, backpressure on word 1
    step(1'b1, TEST_LINE, 3'b000, 1'b1, 1'b1, 1'b0);
    idle_cycles(1, 1'b1);
    idle_cycles(3, 1'b0);
    idle_cycles(4, 1'b1);

    // 4: burst from word 1, flush after two handshakes, then a fresh line
    step(1'b1, TEST_LINE, 3'b010, 1'b1, 1'b1, 1'b0);
    idle_cycles(2, 1'b1);
    step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    idle_cycles(1, 1'b1);
    step(1'b1, 64'hdddd_cccc_bbbb_aaaa, 3'b111, 1'b1, 1'b1, 1'b0);
    idle_cycles(5, 1'b1);

    // 5: asynchronous reset mid-burst
    step(1'b1, TEST_LINE, 3'b100, 1'b1, 1'b1, 1'b0);
    step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
    line_valid = 1'b0; flush = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    pending.delete();
    check_outputs(1'b0);
    #1 rst_n = 1'b1;
    @(negedge clk);
    idle_cycles(3, 1'b1);

    // 6: line offered together with flush is refused, then accepted
    step(1'b1, TEST_LINE, 3'b011, 1'b1, 1'b1, 1'b1);
    step(1'b1, TEST_LINE, 3'b011, 1'b1, 1'b1, 1'b0);
    idle_cycles(5, 1'b1);

    // random traffic
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 1)), {$urandom, $urandom}, 3'($urandom),
           1'($urandom), ($urandom_range(0, 9) < 7), ($urandom_range(0, 19) == 0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/line_word_burst_unit.md
# line_word_burst_unit

Parametrised line-to-word read path between the RAM-side line buffer and the CPU data port. Captures one full cache line through a valid/ready handshake, then delivers either the single addressed CPU word or the whole line as a critical-word-first burst with wrap-around. Each word is delivered through a valid/ready handshake with backpressure. It generalises the fixed 4-word, combinational word select to any power-of-two line length and adds buffering, sequencing, flush and flow control.

## Interface
- `CPU_DATA_SIZE`, 16: width of one CPU word in bits.
- `WORDS_PER_LINE`, 4: words per cache line; must be a power of two, ≥ 2.
- `BYTE_SEL_SIZE`, 1: low offset bits that select a byte inside a word; these bits are ignored by this unit.
- Derived localparam `WORD_SEL_SIZE` = log2(`WORDS_PER_LINE`).
- Derived localparam `LINE_SIZE` = `CPU_DATA_SIZE`*`WORDS_PER_LINE`.

Ports (one clock; reset is asynchronous and active-low):
- `IN_CLK`  in  1  rising-edge clock.
- `IN_RESET_N`  in  1  asynchronous active-low reset.
- `IN_LINE_VALID`  in  1  a line is offered.
- `OUT_LINE_READY`  out  1  the unit accepts a line this cycle.
- `IN_LINE_DATA`  in  `LINE_SIZE`  line; word i occupies bits [`CPU_DATA_SIZE`*(i+1)-1 : `CPU_DATA_SIZE`*i].
- `IN_ADDR_OFFSET`  in  `WORD_SEL_SIZE`+`BYTE_SEL_SIZE`  address offset; the upper `WORD_SEL_SIZE` bits give the critical word index.
- `IN_MODE`  in  1  0 = single word, 1 = full-line burst; sampled with the line.
- `IN_FLUSH`  in  1  synchronous abort of the current transfer.
- `OUT_WORD_VALID`  out  1  a word is presented.
- `IN_WORD_READY`  in  1  the consumer takes the word.
- `OUT_WORD_DATA`  out  `CPU_DATA_SIZE`  presented word.
- `OUT_WORD_INDEX`  out  `WORD_SEL_SIZE`  index of that word within the line.
- `OUT_WORD_LAST`  out  1  final word of the transfer.
- `OUT_BUSY`  out  1  a transfer is in progress (state SEND).

## Operation
- The unit has two states, IDLE and SEND. Reset state is IDLE.
- `OUT_LINE_READY` = (state == IDLE) && !`IN_FLUSH`.
- **Line accept.** When `IN_LINE_VALID` && `OUT_LINE_READY` at a clock edge, the unit:
  - registers `IN_LINE_DATA` into the line buffer;
  - registers the start index (word bits of `IN_ADDR_OFFSET`) and `IN_MODE`;
  - clears the word counter to 0;
  - moves to SEND.
- **In SEND.**
  - `OUT_WORD_VALID` = 1.
  - Index = (start + count) mod `WORDS_PER_LINE`; the sum is truncated to `WORD_SEL_SIZE` bits, which gives the wrap-around.
  - `OUT_WORD_DATA` = buffered word[index].
  - `OUT_WORD_INDEX` = index.
  - `OUT_WORD_LAST` = mode ? (count == `WORDS_PER_LINE`-1) : 1.
- **Word handshake** (`OUT_WORD_VALID` && `IN_WORD_READY`):
  - if not last: count increments;
  - if last: state goes to IDLE.
- **Backpressure.** While valid && !ready, all word outputs hold stable and the count does not advance.
- **Flush.** `IN_FLUSH` high at an edge forces IDLE. Flush has priority over the word handshake and over line accept. A word handshaken in the same cycle as a flush counts as delivered, but no further words follow.
- **Idle outputs.** Outside SEND, `OUT_WORD_VALID`, `OUT_WORD_DATA`, `OUT_WORD_INDEX`, `OUT_WORD_LAST` and `OUT_BUSY` are all 0.
- **Ignored inputs.** `IN_LINE_DATA`, `IN_ADDR_OFFSET` and `IN_MODE` are ignored outside an accept edge. Changing them during SEND has no effect.
- **Reset mid-operation.** Asserting `IN_RESET_N` low at any time immediately, without a clock edge:
  - forces IDLE;
  - clears the line buffer, start index, mode and count to 0.
  - The transfer in progress is discarded.

## Timing
- **Reset values:**
  - `OUT_LINE_READY` 1 (0 if `IN_FLUSH` is high);
  - `OUT_WORD_VALID` 0, `OUT_WORD_DATA` 0, `OUT_WORD_INDEX` 0, `OUT_WORD_LAST` 0, `OUT_BUSY` 0.
- **Latency.** A line accepted at edge k presents its first word from edge k to k+1, i.e. one cycle accept-to-word.
- **Throughput.** With `IN_WORD_READY` held high:
  - burst mode delivers `WORDS_PER_LINE` words on consecutive cycles;
  - single mode delivers 1 word.
- **Line period.** `OUT_LINE_READY` rises in the cycle after the last-word handshake, so there is one bubble. Minimum line period is `WORDS_PER_LINE`+1 cycles in burst mode and 2 cycles in single mode.
- **Flush timing.** Flush asserted at edge m: `OUT_WORD_VALID` is 0 and `OUT_LINE_READY` is 1 from edge m onward, provided flush is low again.
- **Output sourcing.** All word outputs are decoded from registered state only. There is no combinational path from `IN_WORD_READY` or `IN_LINE_VALID` to any output. The one exception is `IN_FLUSH`, which drives `OUT_LINE_READY` combinationally.

## Test plan
Default parameters are used throughout. The test line is 0x4444_3333_2222_1111 (word3..word0).

1. **Burst, offset 'b101 (word 2), ready held high** -> words 0x3333/2, 0x4444/3, 0x1111/0, 0x2222/1 on 4 consecutive cycles. LAST is set only on 0x2222. READY returns 1 on the following cycle.
2. **Single mode, offset 'b110 (word 3)** -> exactly one word 0x4444, index 3, LAST=1. IDLE on the next cycle.
3. **Burst from word 0; `IN_WORD_READY` low for 3 cycles while word 1 is presented** -> 0x2222/1 held stable for all 3 cycles. No word is skipped or duplicated; 0x3333 and 0x4444 then follow.
4. **Burst from word 1; flush pulse after 2 handshakes** -> VALID is 0 on the next cycle, READY=1, BUSY=0. A new line offered afterwards is accepted, and its burst starts at its own offset.
5. **`IN_RESET_N` pulled low mid-burst, between clock edges** -> VALID, DATA, INDEX, LAST and BUSY go to 0 immediately. After release, READY=1 and no stale word appears.
6. **In IDLE, `IN_LINE_VALID`=1 and `IN_FLUSH`=1 in the same cycle** -> READY=0 and the line is not accepted. With flush low on the next cycle, the line is accepted and the burst proceeds normally.
